// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU M-stage
// and a DMA/loader port. CPU has priority, a starvation counter forces a DMA
// grant after MAX_WAIT denied cycles, and locked bursts hold the memory for
// up to MAX_BURST consecutive DMA accesses.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WAIT  = 3,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W  = (MAX_WAIT  + 1 > 1) ? $clog2(MAX_WAIT  + 1) : 1;
  localparam int unsigned BURST_W = (MAX_BURST + 1 > 1) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {
    S_CPU   = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [WAIT_W-1:0]    w_wait_nxt;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [BURST_W-1:0]   w_burst_nxt;
  logic                 r_dma_rvalid;
  logic [DATA_W-1:0]    r_dma_rdata;

  logic                 w_cpu_gnt;
  logic                 w_dma_gnt;
  logic                 w_starved;
  logic                 w_arb_cpu;
  logic                 w_arb_dma;
  logic                 w_burst_go;

  // Plain priority arbitration shared by S_CPU and the burst-exit path
  assign w_starved  = dma_req && (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign w_arb_dma  = w_starved || (!cpu_req && dma_req);
  assign w_arb_cpu  = cpu_req && !w_starved;
  assign w_burst_go = dma_req && dma_lock && (r_burst_cnt < BURST_W'(MAX_BURST));

  // Next-state and grant decode
  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    if (!Reset) begin
      w_state_nxt = S_CPU;
      w_burst_nxt = '0;
    end else begin
      case (r_state)
        S_CPU: begin
          w_cpu_gnt = w_arb_cpu;
          w_dma_gnt = w_arb_dma;
          if (w_arb_dma && dma_lock) begin
            w_state_nxt = S_BURST;
            w_burst_nxt = BURST_W'(1);
          end
        end
        S_BURST: begin
          if (w_burst_go) begin
            w_dma_gnt   = 1'b1;
            w_burst_nxt = r_burst_cnt + BURST_W'(1);
          end else begin
            // Exit grants never re-enter the burst; a new one needs S_CPU
            w_cpu_gnt   = w_arb_cpu;
            w_dma_gnt   = w_arb_dma;
            w_state_nxt = S_CPU;
            w_burst_nxt = '0;
          end
        end
      endcase
    end
  end

  // Starvation counter: cleared on grant or idle DMA, else saturating count
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!dma_req || w_dma_gnt) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end
  end

  // State, counters and registered DMA read return
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state      <= S_CPU;
      r_wait_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_dma_rvalid <= w_dma_gnt && !dma_we;
      if (w_dma_gnt && !dma_we) begin
        r_dma_rdata <= mem_rdata;
      end
    end
  end

  // Memory bus steering; CPU values are parked on the bus when nobody is granted
  assign mem_we    = (w_cpu_gnt && cpu_we) || (w_dma_gnt && dma_we);
  assign mem_addr  = w_dma_gnt ? dma_addr  : cpu_addr;
  assign mem_wdata = w_dma_gnt ? dma_wdata : cpu_wdata;

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = Reset && cpu_req && !w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign dma_rvalid = r_dma_rvalid;
  assign dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a count-based behavioural model and a shadow memory.
module tb_dmem_arbiter;

  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned MAX_WAIT  = 3;
  localparam int unsigned MAX_BURST = 4;

  logic          CLK;
  logic          Reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Physical memory seen by the DUT and the reference copy kept by the model
  logic [DW-1:0] phys [256];
  logic [DW-1:0] refm [256];
  assign mem_rdata = phys[mem_addr[9:2]];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state expressed as counts of history, not as a state encoding
  int unsigned m_denied;
  int unsigned m_burst_run;
  bit          m_rvalid;
  logic [DW-1:0] m_rdata;

  // Expectations for the cycle currently being driven
  bit            exp_cpu, exp_dma, exp_we, exp_stall;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rd;
  bit            s_rst, s_dr, s_dw, s_dl;

  // Drive one cycle of inputs after the falling edge and derive expectations
  task automatic set_inputs(input bit rst, input bit cr, input bit cw,
                            input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                            input bit dr, input bit dw, input bit dl,
                            input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(negedge CLK);
    Reset = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
    s_rst = rst; s_dr = dr; s_dw = dw; s_dl = dl;
    #1;
    exp_cpu = 1'b0;
    exp_dma = 1'b0;
    if (rst) begin
      if (m_burst_run > 0 && m_burst_run < MAX_BURST && dr && dl) exp_dma = 1'b1;
      else if (dr && m_denied >= MAX_WAIT)                         exp_dma = 1'b1;
      else if (cr)                                                 exp_cpu = 1'b1;
      else if (dr)                                                 exp_dma = 1'b1;
    end
    exp_we    = exp_cpu ? cw : (exp_dma ? dw : 1'b0);
    exp_addr  = exp_dma ? da : ca;
    exp_wdata = exp_dma ? dd : cd;
    exp_stall = rst && cr && !exp_cpu;
    exp_rd    = refm[exp_addr[9:2]];
  endtask

  // Advance through the rising edge, then apply the write and update the model
  task automatic commit();
    logic          cap_we;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    cap_we = mem_we; cap_a = mem_addr; cap_d = mem_wdata;
    @(posedge CLK);
    #1;
    if (cap_we) phys[cap_a[9:2]] = cap_d;
    if (!s_rst) begin
      m_denied = 0; m_burst_run = 0; m_rvalid = 1'b0; m_rdata = '0;
    end else begin
      if (!s_dr || exp_dma)         m_denied = 0;
      else if (m_denied < MAX_WAIT) m_denied = m_denied + 1;
      if (exp_dma) begin
        if (m_burst_run > 0 && m_burst_run < MAX_BURST && s_dl) m_burst_run = m_burst_run + 1;
        else if (m_burst_run == 0 && s_dl)                       m_burst_run = 1;
        else                                                     m_burst_run = 0;
      end else begin
        m_burst_run = 0;
      end
      m_rvalid = exp_dma && !s_dw;
      if (exp_dma && !s_dw) m_rdata = exp_rd;
      if (exp_we) refm[exp_addr[9:2]] = exp_wdata;
    end
  endtask

  task automatic idle();
    set_inputs(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    commit();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      set_inputs(0, 1, 1, 32'h80, 32'h5, 1, 1, 1, 32'h84, 32'h6);
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
      n_vec++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dma_gnt: got %b expected 0", dma_gnt); end
      n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_cpu_stall: got %b expected 0", cpu_stall); end
      commit();
      n_vec++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_dma_rvalid: got %b expected 0", dma_rvalid); end
      n_vec++; if (dma_rdata !== 32'h0) begin n_err++; $display("FAIL reset_dma_rdata: got %h expected 0", dma_rdata); end
    end
    set_inputs(1, 1, 0, 32'h80, 32'h0, 1, 0, 0, 32'h84, 32'h0);
    n_vec++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL release_dma_gnt: got %b expected 0", dma_gnt); end
    n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL release_cpu_stall: got %b expected 0", cpu_stall); end
    n_vec++; if (mem_addr !== 32'h80) begin n_err++; $display("FAIL release_mem_addr: got %h expected 00000080", mem_addr); end
    commit();
  endtask

  task automatic test_cpu_priority();
    logic [DW-1:0] word;
    idle();
    word = refm[32'h40 >> 2];
    for (int c = 1; c <= 4; c++) begin
      set_inputs(1, 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h40, 32'h0);
      n_vec++; if (dma_gnt !== (c == 4)) begin n_err++; $display("FAIL prio_dma_gnt c%0d: got %b expected %b", c, dma_gnt, c == 4); end
      n_vec++; if (cpu_stall !== (c == 4)) begin n_err++; $display("FAIL prio_cpu_stall c%0d: got %b expected %b", c, cpu_stall, c == 4); end
      if (c == 4) begin
        n_vec++; if (mem_addr !== 32'h40) begin n_err++; $display("FAIL prio_mem_addr: got %h expected 00000040", mem_addr); end
      end
      commit();
    end
    set_inputs(1, 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h40, 32'h0);
    n_vec++; if (dma_rvalid !== 1'b1) begin n_err++; $display("FAIL prio_rvalid: got %b expected 1", dma_rvalid); end
    n_vec++; if (dma_rdata !== word) begin n_err++; $display("FAIL prio_rdata: got %h expected %h", dma_rdata, word); end
    n_vec++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL prio_wait_restart: got %b expected 0", dma_gnt); end
    commit();
    set_inputs(1, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h40, 32'h0);
    n_vec++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL prio_rvalid_once: got %b expected 0", dma_rvalid); end
    commit();
  endtask

  task automatic test_idle_cpu();
    idle();
    set_inputs(1, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
    n_vec++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL idle_dma_gnt: got %b expected 1", dma_gnt); end
    n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL idle_mem_we: got %b expected 1", mem_we); end
    n_vec++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL idle_mem_addr: got %h expected 00000010", mem_addr); end
    n_vec++; if (mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_mem_wdata: got %h expected deadbeef", mem_wdata); end
    commit();
    set_inputs(1, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    n_vec++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_readback: got %h expected deadbeef", cpu_rdata); end
    n_vec++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL idle_no_rvalid: got %b expected 0", dma_rvalid); end
    commit();
  endtask

  task automatic test_burst_limit();
    idle();
    // Three starved cycles, four locked DMA grants, then the CPU again
    for (int c = 1; c <= 8; c++) begin
      set_inputs(1, 1, 0, 32'h0, 32'h0, 1, 0, 1, 32'h44 + AW'(c * 4), 32'h0);
      n_vec++; if (dma_gnt !== (c >= 4 && c <= 7)) begin n_err++; $display("FAIL burst_dma_gnt c%0d: got %b expected %b", c, dma_gnt, c >= 4 && c <= 7); end
      n_vec++; if (cpu_stall !== (c >= 4 && c <= 7)) begin n_err++; $display("FAIL burst_stall c%0d: got %b expected %b", c, cpu_stall, c >= 4 && c <= 7); end
      commit();
    end
    idle();
  endtask

  task automatic test_burst_abort();
    idle();
    for (int c = 1; c <= 2; c++) begin
      set_inputs(1, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h60, 32'h0);
      n_vec++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL abort_grant c%0d: got %b expected 1", c, dma_gnt); end
      commit();
    end
    set_inputs(1, 1, 0, 32'h8, 32'h0, 0, 0, 1, 32'h60, 32'h0);
    n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL abort_cpu_stall: got %b expected 0", cpu_stall); end
    n_vec++; if (mem_addr !== 32'h8) begin n_err++; $display("FAIL abort_mem_addr: got %h expected 00000008", mem_addr); end
    commit();
    set_inputs(1, 1, 0, 32'h8, 32'h0, 1, 0, 1, 32'h60, 32'h0);
    n_vec++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL abort_back_in_cpu: got %b expected 0", dma_gnt); end
    commit();
    idle();
    set_inputs(1, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h64, 32'h77);
    n_vec++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL rstburst_grant: got %b expected 1", dma_gnt); end
    commit();
    set_inputs(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h68, 32'h78);
    n_vec++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL rstburst_no_gnt: got %b expected 0", dma_gnt); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rstburst_mem_we: got %b expected 0", mem_we); end
    commit();
    set_inputs(1, 1, 0, 32'h0, 32'h0, 1, 1, 1, 32'h6C, 32'h79);
    n_vec++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL rstburst_state: got %b expected 0", dma_gnt); end
    n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rstburst_stall: got %b expected 0", cpu_stall); end
    commit();
  endtask

  task automatic test_simultaneous_writes();
    idle();
    set_inputs(1, 1, 1, 32'h20, 32'h11, 1, 1, 0, 32'h24, 32'h22);
    n_vec++; if (dma_gnt !== 1'b0 || mem_addr !== 32'h20 || mem_wdata !== 32'h11 || mem_we !== 1'b1) begin
      n_err++; $display("FAIL simul_cpu_first: got gnt=%b addr=%h data=%h we=%b expected gnt=0 addr=00000020 data=00000011 we=1", dma_gnt, mem_addr, mem_wdata, mem_we);
    end
    commit();
    set_inputs(1, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h24, 32'h22);
    n_vec++; if (dma_gnt !== 1'b1 || mem_addr !== 32'h24 || mem_wdata !== 32'h22 || mem_we !== 1'b1) begin
      n_err++; $display("FAIL simul_dma_next: got gnt=%b addr=%h data=%h we=%b expected gnt=1 addr=00000024 data=00000022 we=1", dma_gnt, mem_addr, mem_wdata, mem_we);
    end
    commit();
    set_inputs(1, 1, 0, 32'h20, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    n_vec++; if (cpu_rdata !== 32'h11) begin n_err++; $display("FAIL simul_read20: got %h expected 00000011", cpu_rdata); end
    commit();
    set_inputs(1, 1, 0, 32'h24, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    n_vec++; if (cpu_rdata !== 32'h22) begin n_err++; $display("FAIL simul_read24: got %h expected 00000022", cpu_rdata); end
    commit();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit rst, cr, cw, dr, dw, dl;
      logic [AW-1:0] ca, da;
      rst = ($urandom_range(0, 99) >= 2);
      cr  = ($urandom_range(0, 99) < 60);
      cw  = $urandom_range(0, 1) == 1;
      dr  = ($urandom_range(0, 99) < 60);
      dw  = $urandom_range(0, 1) == 1;
      dl  = ($urandom_range(0, 99) < 55);
      ca  = $urandom() & 32'hFFFF_F0FC;
      da  = $urandom() & 32'hFFFF_F0FC;
      set_inputs(rst, cr, cw, ca, $urandom(), dr, dw, dl, da, $urandom());
      n_vec++; if (dma_gnt !== exp_dma) begin n_err++; $display("FAIL rnd_dma_gnt c%0d: got %b expected %b", c, dma_gnt, exp_dma); end
      n_vec++; if (cpu_stall !== exp_stall) begin n_err++; $display("FAIL rnd_cpu_stall c%0d: got %b expected %b", c, cpu_stall, exp_stall); end
      n_vec++; if (mem_we !== exp_we) begin n_err++; $display("FAIL rnd_mem_we c%0d: got %b expected %b", c, mem_we, exp_we); end
      n_vec++; if (mem_addr !== exp_addr) begin n_err++; $display("FAIL rnd_mem_addr c%0d: got %h expected %h", c, mem_addr, exp_addr); end
      n_vec++; if (mem_wdata !== exp_wdata) begin n_err++; $display("FAIL rnd_mem_wdata c%0d: got %h expected %h", c, mem_wdata, exp_wdata); end
      n_vec++; if (cpu_rdata !== exp_rd) begin n_err++; $display("FAIL rnd_cpu_rdata c%0d: got %h expected %h", c, cpu_rdata, exp_rd); end
      n_vec++; if (dma_rvalid !== m_rvalid) begin n_err++; $display("FAIL rnd_dma_rvalid c%0d: got %b expected %b", c, dma_rvalid, m_rvalid); end
      n_vec++; if (dma_rdata !== m_rdata) begin n_err++; $display("FAIL rnd_dma_rdata c%0d: got %h expected %h", c, dma_rdata, m_rdata); end
      commit();
    end
  endtask

  initial begin
    Reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_wdata = '0;
    m_denied = 0; m_burst_run = 0; m_rvalid = 1'b0; m_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] v;
      v = $urandom();
      phys[i] = v;
      refm[i] = v;
    end
    test_reset();
    test_cpu_priority();
    test_idle_cpu();
    test_burst_limit();
    test_burst_abort();
    test_simultaneous_writes();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
